// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Purpose  : Instruction fetch unit front end. Generates fetch PCs with a
//            selectable static predictor and issues one outstanding request
//            at a time to the ICache. Fetched {pc, inst} pairs are buffered
//            in a QDEPTH-entry queue ahead of the decode stage. Jump and
//            CSR/trap redirects toggle an epoch bit so that responses still
//            in flight are discarded when they return.
// Ports    : clock, reset (async, active-low)
//            req_valid/req_ready/req_addr    - ICache request handshake
//            resp_valid/resp_inst            - ICache response (1-cycle pulse)
//            jump_flush/jump_dnpc            - EXU redirect
//            cs_flush/cs_dnpc                - CSR/trap redirect (wins over jump)
//            out_valid/out_ready/out_pc/out_inst - queue head towards IDU
//            q_count                         - queue occupancy
//            perf_fetch/perf_drop            - performance counters
// Options  : `define IFU_QUEUE_PERF_EN to build the saturating perf counters;
//            otherwise both perf outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue #(
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter int unsigned BP_MODE  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [31:0]              req_addr,
  input  logic                     resp_valid,
  input  logic [31:0]              resp_inst,
  input  logic                     jump_flush,
  input  logic [31:0]              jump_dnpc,
  input  logic                     cs_flush,
  input  logic [31:0]              cs_dnpc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic [31:0]              perf_fetch,
  output logic [31:0]              perf_drop
);

  localparam int unsigned AW      = $clog2(QDEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic          epoch;
  logic          req_epoch;
  logic          outstanding;
  logic [PW-1:0] wptr, rptr;
  logic [31:0]   pc_mem   [QDEPTH];
  logic [31:0]   inst_mem [QDEPTH];

  logic          flush;
  logic [31:0]   dnpc;
  logic          empty;
  logic          pop;
  logic          accept;
  logic          resp_fire;
  logic          push;
  logic          outstanding_nxt;
  logic [PW:0]   occupancy;
  logic          room;
  logic          is_system;
  logic [31:0]   incr;

  assign flush     = jump_flush | cs_flush;
  assign dnpc      = cs_flush ? cs_dnpc : jump_dnpc;

  assign q_count   = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign out_valid = ~empty & ~flush;
  assign pop       = out_valid & out_ready;
  assign out_pc    = pc_mem[rptr[AW-1:0]];
  assign out_inst  = inst_mem[rptr[AW-1:0]];

  assign req_valid = (state == REQ);
  assign req_addr  = fetch_pc;
  assign accept    = (state == REQ) & req_ready;

  // A response is only meaningful while a request is outstanding; it is kept
  // only if it belongs to the current epoch and no redirect is in progress.
  assign resp_fire = resp_valid & outstanding;
  assign push      = resp_fire & (req_epoch == epoch) & ~flush;
  assign is_system = (resp_inst[6:2] == 5'b11100);

  assign outstanding_nxt = accept | (outstanding & ~resp_valid);

  // Slots already holding data plus the one reserved by an in-flight request
  // must leave room, so a returning response can never overflow the queue.
  assign occupancy = {1'b0, q_count} + {{PW{1'b0}}, outstanding};
  assign room      = (occupancy < DEPTH_W);

  generate
    if (BP_MODE == 1) begin : g_bp_static
      logic [31:0] imm_b;
      logic [31:0] imm_j;
      assign imm_b = {{20{resp_inst[31]}}, resp_inst[7], resp_inst[30:25],
                      resp_inst[11:8], 1'b0};
      assign imm_j = {{12{resp_inst[31]}}, resp_inst[19:12], resp_inst[20],
                      resp_inst[30:21], 1'b0};
      always_comb begin
        incr = 32'd4;
        // Backward conditional branches are predicted taken; JAL always.
        if (resp_inst[6:2] == 5'b11000 && resp_inst[31]) begin
          incr = imm_b;
        end else if (resp_inst[6:2] == 5'b11011) begin
          incr = imm_j;
        end
      end
    end else begin : g_bp_seq
      assign incr = 32'd4;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // Keep waiting if a request (including one accepted right now) still
      // owes a response, so that response is consumed and discarded.
      state_nxt = outstanding_nxt ? WAIT : IDLE;
    end else begin
      case (state)
        IDLE:    if (room) state_nxt = REQ;
        REQ:     if (req_ready) state_nxt = WAIT;
        WAIT:    if (resp_fire) state_nxt = (push & is_system) ? STALL : IDLE;
        STALL:   state_nxt = STALL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      epoch       <= 1'b0;
      req_epoch   <= 1'b0;
      outstanding <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      if (accept) begin
        req_epoch <= epoch;
      end
      if (flush) begin
        epoch    <= ~epoch;
        fetch_pc <= dnpc;
        rptr     <= wptr;
      end else begin
        if (push) begin
          pc_mem[wptr[AW-1:0]]   <= fetch_pc;
          inst_mem[wptr[AW-1:0]] <= resp_inst;
          wptr                   <= wptr + PW'(1);
          fetch_pc               <= fetch_pc + incr;
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
      end
    end
  end

`ifdef IFU_QUEUE_PERF_EN
  logic        drop;
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;

  assign drop = resp_fire & ~push;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push && fetch_cnt != 32'hFFFF_FFFF) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (drop && drop_cnt != 32'hFFFF_FFFF) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch = fetch_cnt;
  assign perf_drop  = drop_cnt;
`else
  assign perf_fetch = '0;
  assign perf_drop  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_queue
// Purpose  : Self-checking bench for ifu_fetch_queue. An ICache model answers
//            accepted requests after a programmable latency; a bench-side PC
//            model predicts every request address, and expected {pc, inst}
//            pairs are queued and compared as the DUT presents them to IDU.
//            A second instance with BP_MODE=0 shares all inputs so the two
//            predictor modes can be compared on the same stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h3000_0000;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_ready, resp_valid, jump_flush, cs_flush, out_ready;
  logic [31:0] resp_inst, jump_dnpc, cs_dnpc;

  logic        req_valid, out_valid;
  logic [31:0] req_addr, out_pc, out_inst, perf_fetch, perf_drop;
  logic [2:0]  q_count;

  logic        b_req_valid, b_out_valid;
  logic [31:0] b_req_addr, b_out_pc, b_out_inst, b_perf_fetch, b_perf_drop;
  logic [2:0]  b_q_count;

  always #5 clock = ~clock;

  ifu_fetch_queue #(.QDEPTH(4), .RESET_PC(RST_PC), .BP_MODE(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .q_count(q_count),
    .perf_fetch(perf_fetch), .perf_drop(perf_drop)
  );

  ifu_fetch_queue #(.QDEPTH(4), .RESET_PC(RST_PC), .BP_MODE(0)) dut_bp0 (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(req_ready), .req_addr(b_req_addr),
    .resp_valid(resp_valid), .resp_inst(resp_inst),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .q_count(b_q_count),
    .perf_fetch(b_perf_fetch), .perf_drop(b_perf_drop)
  );

  int          checks   = 0;
  int          failures = 0;
  int          n_acc    = 0;
  int          n_resp   = 0;
  int          gen      = 0;
  int          rgen     = 0;
  int          lat      = 0;
  int          exp_fetch = 0;
  int          exp_drop  = 0;
  logic [31:0] model_pc  = RST_PC;
  logic [31:0] model_b   = RST_PC;
  logic [63:0] sb [$];
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ADDI;
  endfunction

  // Static prediction reference (BP_MODE=1), built from RISC-V field layout.
  function automatic logic [31:0] pred_incr(input logic [31:0] i);
    logic [31:0] off;
    off = 32'd4;
    if (i[6:0] == 7'b1100011 && i[31])
      off = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    else if (i[6:0] == 7'b1101111)
      off = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    return off;
  endfunction

  // ICache model: one outstanding request, response after 'lat' extra cycles.
  initial begin : icache
    logic [31:0] a;
    int g, rg;
    resp_valid = 1'b0;
    resp_inst  = '0;
    forever begin
      @(negedge clock);
      if (reset && req_valid && req_ready) begin
        chk("req_addr", {32'd0, req_addr}, {32'd0, model_pc});
        chk("req_addr_bp0", {32'd0, b_req_addr}, {32'd0, model_b});
        a = model_pc; g = gen; rg = rgen; n_acc++;
        @(posedge clock); #1;
        repeat (lat) begin @(posedge clock); #1; end
        resp_inst  = imem(a);
        resp_valid = 1'b1;
        @(posedge clock); #1;
        resp_valid = 1'b0;
        if (rg == rgen) begin
          if (g == gen) begin
            sb.push_back({a, resp_inst});
            model_pc = a + pred_incr(resp_inst);
            model_b  = model_b + 32'd4;
            n_resp++;
            exp_fetch++;
          end else begin
            exp_drop++;
          end
        end
      end
    end
  end

  // IDU-side monitor: every pop must match the oldest expected entry.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (reset && out_valid && out_ready) begin
        if (sb.size() != 0) e = sb.pop_front();
        else e = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("out_pc", {32'd0, out_pc}, {32'd0, e[63:32]});
        chk("out_inst", {32'd0, out_inst}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (n_acc < target && k < budget) begin
      @(posedge clock); #1; k++;
    end
    chk("acc_count", 64'(n_acc), 64'(target));
  endtask

  task automatic chk_perf();
`ifdef IFU_QUEUE_PERF_EN
    chk("perf_fetch", {32'd0, perf_fetch}, 64'(exp_fetch));
    chk("perf_drop", {32'd0, perf_drop}, 64'(exp_drop));
`else
    chk("perf_fetch", {32'd0, perf_fetch}, 64'd0);
    chk("perf_drop", {32'd0, perf_drop}, 64'd0);
`endif
  endtask

  task automatic redirect(input logic [31:0] pc);
    gen++;
    sb.delete();
    model_pc = pc;
    model_b  = pc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rgen++; gen++;
    jump_flush = 1'b0; cs_flush = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_q_count", {61'd0, q_count}, 64'd0);
    chk("rst_perf_fetch", {32'd0, perf_fetch}, 64'd0);
    chk("rst_perf_drop", {32'd0, perf_drop}, 64'd0);
    repeat (6) @(posedge clock);
    sb.delete();
    mem.delete();
    model_pc = RST_PC; model_b = RST_PC;
    exp_fetch = 0; exp_drop = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin : seq
    int k, acc0, r0;
    reset = 1'b0; req_ready = 1'b1; out_ready = 1'b1;
    jump_flush = 1'b0; cs_flush = 1'b0; jump_dnpc = '0; cs_dnpc = '0;

    // Basic streaming with single-cycle ICache latency.
    do_reset();
    lat = 0;
    wait_acc(n_acc + 4, 60);
    @(negedge clock);
    chk_perf();

    // IDU stalled: queue fills to QDEPTH and fetching stops, then drains.
    do_reset();
    out_ready = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (q_count != 3'd4 && k < 60);
    chk("q_full", {61'd0, q_count}, 64'd4);
    chk("out_valid_full", {63'd0, out_valid}, 64'd1);
    repeat (4) begin
      @(negedge clock);
      chk("req_hold_full", {63'd0, req_valid}, 64'd0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_acc(n_acc + 1, 40);

    // Backward branch: BP_MODE=1 loops back, BP_MODE=0 falls through.
    do_reset();
    mem[RST_PC + 32'd8] = BEQ_M8;
    wait_acc(n_acc + 5, 80);

    // Jump flush while a response is still in flight: it must be dropped.
    do_reset();
    lat = 4;
    acc0 = n_acc;
    wait_acc(acc0 + 2, 60);
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0100;
    cyc(1);
    jump_flush = 1'b0;
    redirect(32'h3000_0100);
    @(negedge clock);
    chk("flush_q_empty", {61'd0, q_count}, 64'd0);
    wait_acc(acc0 + 3, 60);
    @(negedge clock);
    chk_perf();

    // Simultaneous flushes on a request held in REQ: cs wins, request retracts.
    do_reset();
    lat = 0;
    req_ready = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (!req_valid && k < 20);
    chk("req_pending", {63'd0, req_valid}, 64'd1);
    @(posedge clock); #1;
    jump_flush = 1'b1; jump_dnpc = 32'h3000_0200;
    cs_flush   = 1'b1; cs_dnpc   = 32'h3000_0400;
    cyc(1);
    jump_flush = 1'b0; cs_flush = 1'b0;
    redirect(32'h3000_0400);
    @(negedge clock);
    chk("req_retract", {63'd0, req_valid}, 64'd0);
    @(posedge clock); #1;
    req_ready = 1'b1;
    wait_acc(n_acc + 1, 20);

    // SYSTEM instruction stalls fetch until a CSR redirect.
    do_reset();
    lat = 0;
    out_ready = 1'b0;
    mem[RST_PC + 32'd4] = ECALL;
    r0 = n_resp;
    k = 0;
    while (n_resp < r0 + 2 && k < 40) begin @(posedge clock); #1; k++; end
    acc0 = n_acc;
    cyc(6);
    chk("stall_no_req", 64'(n_acc), 64'(acc0));
    @(negedge clock);
    chk("stall_req_valid", {63'd0, req_valid}, 64'd0);
    chk("stall_q_count", {61'd0, q_count}, 64'd2);
    chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clock); #1;
    cs_flush = 1'b1; cs_dnpc = 32'h3000_0800;
    @(negedge clock);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clock); #1;
    cs_flush = 1'b0;
    redirect(32'h3000_0800);
    @(negedge clock);
    chk("cs_flush_q_empty", {61'd0, q_count}, 64'd0);
    out_ready = 1'b1;
    lat = 3;
    wait_acc(acc0 + 1, 30);
    wait_acc(acc0 + 2, 30);
    @(negedge clock);
    chk_perf();
    cyc(1);

    // Reset in the middle of WAIT restarts from RESET_PC with an empty queue.
    do_reset();
    wait_acc(n_acc + 1, 30);
    @(negedge clock);
    chk("post_rst_q_count", {61'd0, q_count}, 64'd0);
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Next-generation instruction fetch unit.
- Generates fetch PCs with selectable static prediction and issues single-outstanding requests to the ICache over a req/resp handshake.
- Buffers fetched {pc, inst} pairs in a parametrised queue ahead of IDU.
- Handles jump/CSR flushes with epoch-tagged discard of in-flight responses. Sits between the ICache and the IFU/IDU pipeline register.

Parameters:
- QDEPTH, 4, instruction queue entries; power of 2, >=2.
- RESET_PC, 32'h30000000, first fetch address after reset.
- BP_MODE, 1, static predictor: 0 = always pc+4; 1 = JAL taken, backward conditional branches taken.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- req_valid  out  1  ICache fetch request valid
- req_ready  in  1  ICache accepts request
- req_addr  out  32  fetch address
- resp_valid  in  1  ICache returns instruction (one cycle pulse)
- resp_inst  in  32  fetched instruction
- jump_flush  in  1  EXU redirect
- jump_dnpc  in  32  redirect target
- cs_flush  in  1  CSR/trap redirect; priority over jump_flush
- cs_dnpc  in  32  CSR/trap target
- out_valid  out  1  queue head valid to IDU
- out_ready  in  1  IDU accepts head
- out_pc  out  32  head PC
- out_inst  out  32  head instruction
- q_count  out  $clog2(QDEPTH)+1  current occupancy
- perf_fetch  out  32  perf counter: accepted responses pushed
- perf_drop  out  32  perf counter: responses discarded by epoch mismatch

Behaviour:
- Reset (reset==0, asynchronous):
  - State IDLE; fetch_pc=RESET_PC; epoch=0; outstanding=0; queue empty.
  - Pointers 0; storage cleared to 0.
  - Outputs: req_valid=0, out_valid=0, out_pc=0, out_inst=0, q_count=0, perf counters=0.
- State machine:
  - IDLE: issue when ~flush and (q_count + outstanding) < QDEPTH; then assert req_valid with req_addr=fetch_pc -> REQ.
  - REQ: hold req_valid and req_addr stable. On req_ready, capture req_epoch=epoch, set outstanding=1 -> WAIT.
  - WAIT: on resp_valid, clear outstanding.
    - If req_epoch==epoch and no flush this cycle: push {fetch_pc, resp_inst} and set fetch_pc=fetch_pc+incr.
    - If resp_inst[6:2]==5'b11100 (SYSTEM) -> STALL; otherwise -> IDLE.
    - A mismatched response is dropped -> IDLE.
  - STALL: no requests; exit only on flush.
- resp_valid arrives no earlier than the cycle after acceptance. resp_valid with outstanding==0 is ignored.
- Prediction increment (32-bit, wraps mod 2^32):
  - BP_MODE=0: 4.
  - BP_MODE=1: branch (opcode 11000) -> imm_b if inst[31] else 4; JAL (11011) -> imm_j; else 4.
- Flush (jump_flush|cs_flush); dnpc = cs_flush ? cs_dnpc : jump_dnpc.
  - out_valid is forced 0 in the same cycle; no pop occurs.
  - Next edge: queue emptied, fetch_pc=dnpc, epoch toggled, state -> IDLE (or WAIT if a request is outstanding).
  - A request still in REQ is retracted: req_valid=0 the cycle after the flush.
  - Acceptance in the flush cycle still records the old epoch, so its response is dropped.
- Output side:
  - out_valid = ~empty & ~flush; out_pc/out_inst = head entry.
  - Pop on out_valid & out_ready.
- Queue:
  - Simultaneous push and pop legal at any occupancy; the reservation rule makes overflow impossible.
  - Pointers are $clog2(QDEPTH)+1 bits; full/empty are distinguished by the MSB; wrap is natural.
- Back-to-back throughput: one instruction per request round trip; queue absorbs IDU stalls.

Optional Feature:
- IFU_QUEUE_PERF_EN defined:
  - perf_fetch increments on each pushed response.
  - perf_drop increments on each epoch-mismatched or flush-coincident response.
  - Both saturate at 32'hFFFFFFFF.
- Not defined: both ports tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset released, ICache returns addi (32'h00100093) with 1-cycle latency, out_ready=1:
  - req_addr 32'h30000000, then 32'h30000004.
  - out_valid with out_pc=32'h30000000, out_inst=32'h00100093.
- out_ready=0, QDEPTH=4, continuous hits: q_count reaches 4, req_valid stays 0. Raise out_ready: pops in order, fetching resumes at 32'h30000010.
- Backward beq at 32'h30000008 (imm -8), BP_MODE=1 -> next req_addr 32'h30000000. With BP_MODE=0 -> next req_addr 32'h3000000C.
- Request accepted at 32'h30000004, jump_flush with jump_dnpc=32'h30000100 before the response:
  - Response dropped; perf_drop=1 when IFU_QUEUE_PERF_EN is defined.
  - Next req_addr 32'h30000100; queue empty.
- jump_flush and cs_flush in the same cycle (dnpc 32'h30000200 / 32'h30000400) -> next req_addr 32'h30000400.
- ecall (32'h00000073) fetched:
  - No further requests.
  - cs_flush with cs_dnpc=32'h30000800 resumes fetching at 32'h30000800.
  - reset pulsed mid-WAIT -> returns to RESET_PC with the queue empty.
